// File: rtl/cs_loader.sv
// cs_loader: copies the microcode EPROM into the control-store RAM after
// reset, optionally reads every word back and compares it, and then raises
// cs_ready to hand the control store to the microsequencer.
module cs_loader #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1,
  parameter bit VERIFY       = 1'b1,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cs_ram__w,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  cs_ready,
  output logic                  verify_error,
  output logic [ADDR_WIDTH-1:0] error_addr
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_SETUP  = 4'd2;
  localparam logic [3:0] S_STROBE = 4'd3;
  localparam logic [3:0] S_HOLD   = 4'd4;
  localparam logic [3:0] S_VFETCH = 4'd5;
  localparam logic [3:0] S_VCMP   = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_FAIL   = 4'd8;

  // Wait counter only has to reach READ_LATENCY-1.
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  logic [3:0]            state;
  logic [3:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [LAT_W-1:0]      lat_cnt;
  logic                  lat_done;
  logic                  last;
  logic                  rd_match;

  assign lat_done = (lat_cnt == LAT_LAST);
  assign last     = (idx == LAST_IDX);
  assign rd_match = (rom_data == ram_rdata);

  // Both address buses follow the word index; it is a register, so they are too.
  assign rom_addr = idx;
  assign ram_addr = idx;

  // Next-state decode for the load / verify sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:   if (AUTO_START || start) state_nxt = S_FETCH;
      S_FETCH:  if (lat_done) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_STROBE;
      S_STROBE: state_nxt = S_HOLD;
      S_HOLD: begin
        if (!last)       state_nxt = S_FETCH;
        else if (VERIFY) state_nxt = S_VFETCH;
        else             state_nxt = S_DONE;
      end
      S_VFETCH: if (lat_done) state_nxt = S_VCMP;
      S_VCMP: begin
        if (!rd_match) state_nxt = S_FAIL;
        else if (last) state_nxt = S_DONE;
        else           state_nxt = S_VFETCH;
      end
      S_DONE, S_FAIL: if (start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, index, datapath and registered outputs (decoded from next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      lat_cnt      <= '0;
      ram_wdata    <= '0;
      cs_ram__w    <= 1'b1;
      busy         <= 1'b0;
      cs_ready     <= 1'b0;
      verify_error <= 1'b0;
      error_addr   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_nxt;
      busy      <= (state_nxt != S_IDLE) && (state_nxt != S_DONE) && (state_nxt != S_FAIL);
      cs_ram__w <= (state_nxt != S_STROBE);
      cs_ready  <= (state_nxt == S_DONE);
      lat_cnt   <= (state_nxt == state) ? lat_cnt + LAT_W'(1) : '0;

      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (state_nxt == S_FETCH) begin
            idx          <= '0;
            verify_error <= 1'b0;
            error_addr   <= '0;
          end
        end
        S_FETCH: if (lat_done) ram_wdata <= rom_data;
        S_HOLD:  idx <= last ? '0 : idx + ADDR_WIDTH'(1);
        S_VCMP: begin
          if (!rd_match) begin
            verify_error <= 1'b1;
            error_addr   <= idx;
          end else if (!last) begin
            idx <= idx + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_loader.sv
// tb_cs_loader: directed bench for cs_loader. Three instances share the clock:
// A = defaults, B = VERIFY=0 / READ_LATENCY=2, C = AUTO_START=0. Each has its
// own EPROM / RAM model plus strobe and address/data-stability monitors.
module tb_cs_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] JUNK = 64'hA5A5_5A5A_F00D_CAFE;
  localparam logic [91:0] RST  = {8'h00, 8'h00, 64'h0, 1'b1, 3'b000, 8'h00};

  // ---------------- instance A : defaults ----------------
  logic        reset_a = 1'b1, start_a = 1'b0, ram_clr_a = 1'b1, corrupt_a = 1'b0;
  logic [7:0]  rom_addr_a, ram_addr_a, eaddr_a;
  logic [63:0] rom_data_a, ram_wdata_a, ram_rdata_a;
  logic        we_a, busy_a, ready_a, verr_a;
  logic [63:0] mem_a [256];
  int          wcnt_a [256];
  int          strobes_a = 0, viol_a = 0;
  logic [7:0]  pa_a;
  logic [63:0] pd_a;
  logic        pwe_a;

  assign rom_data_a  = {8{rom_addr_a}};
  assign ram_rdata_a = mem_a[ram_addr_a] ^ ((corrupt_a && ram_addr_a == 8'h3C) ? 64'h20 : 64'h0);

  cs_loader u_a (
    .clk(clk), .reset(reset_a), .start(start_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .cs_ram__w(we_a),
    .ram_rdata(ram_rdata_a), .busy(busy_a), .cs_ready(ready_a),
    .verify_error(verr_a), .error_addr(eaddr_a)
  );

  always @(posedge clk) begin
    if (ram_clr_a) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i]  <= JUNK;
        wcnt_a[i] <= 0;
      end
    end else if (!we_a) begin
      mem_a[ram_addr_a]  <= ram_wdata_a;
      wcnt_a[ram_addr_a] <= wcnt_a[ram_addr_a] + 1;
    end
    if (!we_a) strobes_a <= strobes_a + 1;
    if ((!we_a && (ram_addr_a != pa_a || ram_wdata_a != pd_a)) ||
        (!pwe_a && (!we_a || ram_addr_a != pa_a || ram_wdata_a != pd_a)))
      viol_a <= viol_a + 1;
    pa_a  <= ram_addr_a;
    pd_a  <= ram_wdata_a;
    pwe_a <= we_a;
  end

  // ---------------- instance B : VERIFY=0, READ_LATENCY=2 ----------------
  logic        reset_b = 1'b1, start_b = 1'b0, ram_clr_b = 1'b1;
  logic [7:0]  rom_addr_b, ram_addr_b, eaddr_b;
  logic [63:0] rom_data_b, ram_wdata_b, ram_rdata_b, rom_q_b;
  logic        we_b, busy_b, ready_b, verr_b;
  logic [63:0] mem_b [256];
  int          wcnt_b [256];
  int          strobes_b = 0, viol_b = 0;
  logic [7:0]  pa_b;
  logic [63:0] pd_b;
  logic        pwe_b;

  // Two-cycle EPROM: one register stage behind the address.
  always @(posedge clk) rom_q_b <= {8{rom_addr_b}};
  assign rom_data_b  = rom_q_b;
  // Readback is always wrong here, so any compare would end in FAIL.
  assign ram_rdata_b = ~mem_b[ram_addr_b];

  cs_loader #(.READ_LATENCY(2), .VERIFY(1'b0)) u_b (
    .clk(clk), .reset(reset_b), .start(start_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .cs_ram__w(we_b),
    .ram_rdata(ram_rdata_b), .busy(busy_b), .cs_ready(ready_b),
    .verify_error(verr_b), .error_addr(eaddr_b)
  );

  always @(posedge clk) begin
    if (ram_clr_b) begin
      for (int i = 0; i < 256; i++) begin
        mem_b[i]  <= JUNK;
        wcnt_b[i] <= 0;
      end
    end else if (!we_b) begin
      mem_b[ram_addr_b]  <= ram_wdata_b;
      wcnt_b[ram_addr_b] <= wcnt_b[ram_addr_b] + 1;
    end
    if (!we_b) strobes_b <= strobes_b + 1;
    if ((!we_b && (ram_addr_b != pa_b || ram_wdata_b != pd_b)) ||
        (!pwe_b && (!we_b || ram_addr_b != pa_b || ram_wdata_b != pd_b)))
      viol_b <= viol_b + 1;
    pa_b  <= ram_addr_b;
    pd_b  <= ram_wdata_b;
    pwe_b <= we_b;
  end

  // ---------------- instance C : AUTO_START=0 ----------------
  logic        reset_c = 1'b1, start_c = 1'b0, ram_clr_c = 1'b1;
  logic [7:0]  rom_addr_c, ram_addr_c, eaddr_c;
  logic [63:0] rom_data_c, ram_wdata_c, ram_rdata_c;
  logic        we_c, busy_c, ready_c, verr_c;
  logic [63:0] mem_c [256];
  int          wcnt_c [256];
  int          strobes_c = 0;

  assign rom_data_c  = {8{rom_addr_c}};
  assign ram_rdata_c = mem_c[ram_addr_c];

  cs_loader #(.AUTO_START(1'b0)) u_c (
    .clk(clk), .reset(reset_c), .start(start_c),
    .rom_addr(rom_addr_c), .rom_data(rom_data_c),
    .ram_addr(ram_addr_c), .ram_wdata(ram_wdata_c), .cs_ram__w(we_c),
    .ram_rdata(ram_rdata_c), .busy(busy_c), .cs_ready(ready_c),
    .verify_error(verr_c), .error_addr(eaddr_c)
  );

  always @(posedge clk) begin
    if (ram_clr_c) begin
      for (int i = 0; i < 256; i++) begin
        mem_c[i]  <= JUNK;
        wcnt_c[i] <= 0;
      end
    end else if (!we_c) begin
      mem_c[ram_addr_c]  <= ram_wdata_c;
      wcnt_c[ram_addr_c] <= wcnt_c[ram_addr_c] + 1;
    end
    if (!we_c) strobes_c <= strobes_c + 1;
  end

  // Scoreboard: words whose RAM content is not {8{addr}} or not written exactly once.
  function automatic int bad_words(input int which);
    int         n;
    int         c;
    logic [7:0] a;
    logic [63:0] m;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      a = i[7:0];
      case (which)
        0:       begin m = mem_a[i]; c = wcnt_a[i]; end
        1:       begin m = mem_b[i]; c = wcnt_b[i]; end
        default: begin m = mem_c[i]; c = wcnt_c[i]; end
      endcase
      if (m !== {8{a}} || c != 1) n++;
    end
    return n;
  endfunction

  // Advance edges until the instance reaches DONE or FAIL, bounded by budget.
  task automatic run(input int which, input int k0, input int budget, output int k);
    logic fin;
    k   = k0;
    fin = 1'b0;
    while (!fin && k < budget) begin
      @(posedge clk); #1;
      k++;
      case (which)
        0:       fin = ready_a || verr_a;
        1:       fin = ready_b || verr_b;
        default: fin = ready_c || verr_c;
      endcase
    end
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL run_timeout(inst %0d): edges=%0d, required completion within %0d", which, k, budget);
    end
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    ram_clr_a = 1'b1; ram_clr_b = 1'b1; ram_clr_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rom_addr_a, ram_addr_a, ram_wdata_a, we_a, busy_a, ready_a, verr_a, eaddr_a} !== RST) begin
      bad++; $display("FAIL reset_a: outputs=%h required=%h",
        {rom_addr_a, ram_addr_a, ram_wdata_a, we_a, busy_a, ready_a, verr_a, eaddr_a}, RST);
    end
    total++;
    if ({rom_addr_b, ram_addr_b, ram_wdata_b, we_b, busy_b, ready_b, verr_b, eaddr_b} !== RST) begin
      bad++; $display("FAIL reset_b: outputs=%h required=%h",
        {rom_addr_b, ram_addr_b, ram_wdata_b, we_b, busy_b, ready_b, verr_b, eaddr_b}, RST);
    end
    total++;
    if ({rom_addr_c, ram_addr_c, ram_wdata_c, we_c, busy_c, ready_c, verr_c, eaddr_c} !== RST) begin
      bad++; $display("FAIL reset_c: outputs=%h required=%h",
        {rom_addr_c, ram_addr_c, ram_wdata_c, we_c, busy_c, ready_c, verr_c, eaddr_c}, RST);
    end
  endtask

  task automatic test_load_verify();
    int k, s0, v0;
    @(negedge clk);
    reset_a = 1'b0; ram_clr_a = 1'b0;
    s0 = strobes_a; v0 = viol_a;
    run(0, 0, 4000, k);
    total++;
    if (k !== 1537) begin bad++; $display("FAIL lv_ready_edge: edge=%0d required=1537", k); end
    total++;
    if (ready_a !== 1'b1 || verr_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL lv_flags: ready=%b verr=%b busy=%b required 1 0 0", ready_a, verr_a, busy_a);
    end
    total++;
    if (strobes_a - s0 !== 256) begin bad++; $display("FAIL lv_strobes: count=%0d required=256", strobes_a - s0); end
    total++;
    if (viol_a - v0 !== 0) begin bad++; $display("FAIL lv_stability: violations=%0d required=0", viol_a - v0); end
    total++;
    if (bad_words(0) !== 0) begin bad++; $display("FAIL lv_ram_content: bad words=%0d required=0", bad_words(0)); end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (ready_a !== 1'b1 || we_a !== 1'b1) begin
      bad++; $display("FAIL lv_done_hold: ready=%b we_n=%b required 1 1", ready_a, we_a);
    end
  endtask

  task automatic test_verify_fail();
    int k, s0;
    reset_a = 1'b1; ram_clr_a = 1'b1; corrupt_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_a = 1'b0; ram_clr_a = 1'b0;
    run(0, 0, 4000, k);
    // Index 0x3C is compared at edge 1 + 256*4 + 2*(0x3C+1).
    total++;
    if (k !== 1147) begin bad++; $display("FAIL vf_flag_edge: edge=%0d required=1147", k); end
    total++;
    if (verr_a !== 1'b1 || eaddr_a !== 8'h3C || ready_a !== 1'b0) begin
      bad++; $display("FAIL vf_flags: verr=%b eaddr=%h ready=%b required 1 3c 0", verr_a, eaddr_a, ready_a);
    end
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (verr_a !== 1'b1 || ready_a !== 1'b0 || busy_a !== 1'b0 || rom_addr_a !== 8'h3C) begin
      bad++; $display("FAIL vf_terminal: verr=%b ready=%b busy=%b rom_addr=%h required 1 0 0 3c",
        verr_a, ready_a, busy_a, rom_addr_a);
    end
    corrupt_a = 1'b0;
    @(negedge clk); ram_clr_a = 1'b1;
    @(negedge clk); ram_clr_a = 1'b0; start_a = 1'b1;
    s0 = strobes_a;
    @(posedge clk); #1;
    start_a = 1'b0;
    total++;
    if (verr_a !== 1'b0 || eaddr_a !== 8'h00 || busy_a !== 1'b1) begin
      bad++; $display("FAIL vf_restart_clear: verr=%b eaddr=%h busy=%b required 0 00 1", verr_a, eaddr_a, busy_a);
    end
    run(0, 1, 4000, k);
    total++;
    if (k !== 1537 || ready_a !== 1'b1 || verr_a !== 1'b0) begin
      bad++; $display("FAIL vf_reload: edge=%0d ready=%b verr=%b required 1537 1 0", k, ready_a, verr_a);
    end
    total++;
    if (bad_words(0) !== 0 || strobes_a - s0 !== 256) begin
      bad++; $display("FAIL vf_reload_ram: bad words=%0d strobes=%0d required 0 256", bad_words(0), strobes_a - s0);
    end
  endtask

  task automatic test_mid_reset();
    int k, s0, v0;
    logic found;
    @(negedge clk); reset_a = 1'b1; ram_clr_a = 1'b1;
    @(posedge clk);
    @(negedge clk); reset_a = 1'b0; ram_clr_a = 1'b0;
    k = 0; found = 1'b0;
    while (!found && k < 2000) begin
      @(posedge clk); #1;
      k++;
      found = (ram_addr_a == 8'h80) && (we_a == 1'b0);
    end
    // Word i enters STROBE at edge 3 + 4*i.
    total++;
    if (!found || k !== 515) begin
      bad++; $display("FAIL mr_strobe_80: found=%b edge=%0d required 1 515", found, k);
    end
    reset_a = 1'b1; ram_clr_a = 1'b1;
    @(posedge clk); #1;
    reset_a = 1'b0; ram_clr_a = 1'b0;
    total++;
    if (we_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b0 || rom_addr_a !== 8'h00 || ram_wdata_a !== 64'h0) begin
      bad++; $display("FAIL mr_after_reset: we_n=%b busy=%b ready=%b rom_addr=%h wdata=%h required 1 0 0 00 0",
        we_a, busy_a, ready_a, rom_addr_a, ram_wdata_a);
    end
    @(posedge clk); #1;
    total++;
    if (busy_a !== 1'b1 || rom_addr_a !== 8'h00) begin
      bad++; $display("FAIL mr_restart: busy=%b rom_addr=%h required 1 00", busy_a, rom_addr_a);
    end
    s0 = strobes_a; v0 = viol_a;
    run(0, 1, 4000, k);
    total++;
    if (k !== 1537 || ready_a !== 1'b1 || verr_a !== 1'b0) begin
      bad++; $display("FAIL mr_complete: edge=%0d ready=%b verr=%b required 1537 1 0", k, ready_a, verr_a);
    end
    total++;
    if (bad_words(0) !== 0 || strobes_a - s0 !== 256 || viol_a - v0 !== 0) begin
      bad++; $display("FAIL mr_ram: bad words=%0d strobes=%0d violations=%0d required 0 256 0",
        bad_words(0), strobes_a - s0, viol_a - v0);
    end
  endtask

  task automatic test_done_restart();
    int k, s0;
    total++;
    if (ready_a !== 1'b1) begin bad++; $display("FAIL dr_in_done: ready=%b required 1", ready_a); end
    @(negedge clk); ram_clr_a = 1'b1;
    @(negedge clk); ram_clr_a = 1'b0; start_a = 1'b1;
    s0 = strobes_a;
    @(posedge clk); #1;
    start_a = 1'b0;
    total++;
    if (ready_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++; $display("FAIL dr_drop: ready=%b busy=%b required 0 1", ready_a, busy_a);
    end
    run(0, 1, 4000, k);
    total++;
    if (k !== 1537 || ready_a !== 1'b1) begin
      bad++; $display("FAIL dr_reassert: edge=%0d ready=%b required 1537 1", k, ready_a);
    end
    total++;
    if (bad_words(0) !== 0 || strobes_a - s0 !== 256) begin
      bad++; $display("FAIL dr_ram: bad words=%0d strobes=%0d required 0 256", bad_words(0), strobes_a - s0);
    end
  endtask

  task automatic test_verify_skip();
    int k, s0, v0;
    @(negedge clk);
    reset_b = 1'b0; ram_clr_b = 1'b0;
    s0 = strobes_b; v0 = viol_b;
    run(1, 0, 3000, k);
    total++;
    if (k !== 1281) begin bad++; $display("FAIL vs_ready_edge: edge=%0d required=1281", k); end
    total++;
    if (ready_b !== 1'b1 || verr_b !== 1'b0 || eaddr_b !== 8'h00) begin
      bad++; $display("FAIL vs_no_compare: ready=%b verr=%b eaddr=%h required 1 0 00", ready_b, verr_b, eaddr_b);
    end
    total++;
    if (bad_words(1) !== 0 || strobes_b - s0 !== 256 || viol_b - v0 !== 0) begin
      bad++; $display("FAIL vs_ram: bad words=%0d strobes=%0d violations=%0d required 0 256 0",
        bad_words(1), strobes_b - s0, viol_b - v0);
    end
  endtask

  task automatic test_manual_start();
    int k, s0, idle_bad;
    @(negedge clk);
    reset_c = 1'b0; ram_clr_c = 1'b0;
    idle_bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if ({rom_addr_c, ram_addr_c, ram_wdata_c, we_c, busy_c, ready_c, verr_c, eaddr_c} !== RST) idle_bad++;
    end
    total++;
    if (idle_bad !== 0) begin bad++; $display("FAIL ms_idle: cycles off reset values=%0d required=0", idle_bad); end
    @(negedge clk); start_c = 1'b1;
    s0 = strobes_c;
    @(posedge clk); #1;
    start_c = 1'b0;
    total++;
    if (busy_c !== 1'b1) begin bad++; $display("FAIL ms_start: busy=%b required 1", busy_c); end
    k = 1;
    while (ready_c !== 1'b1 && verr_c !== 1'b1 && k < 4000) begin
      @(posedge clk); #1;
      k++;
      start_c = (k % 200 == 100);
    end
    start_c = 1'b0;
    total++;
    if (k !== 1537 || ready_c !== 1'b1 || verr_c !== 1'b0) begin
      bad++; $display("FAIL ms_complete: edge=%0d ready=%b verr=%b required 1537 1 0", k, ready_c, verr_c);
    end
    total++;
    if (bad_words(2) !== 0 || strobes_c - s0 !== 256) begin
      bad++; $display("FAIL ms_ram: bad words=%0d strobes=%0d required 0 256", bad_words(2), strobes_c - s0);
    end
  endtask

  initial begin
    test_reset();
    test_load_verify();
    test_verify_fail();
    test_mid_reset();
    test_done_restart();
    test_verify_skip();
    test_manual_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cs_loader.md
# cs_loader

Control-store loader for the ECLair microsequencer. After reset it copies every word of the microcode EPROM into the control-store RAM, optionally reads each word back and compares it, and only then raises `cs_ready`. `cs_ready` hands control-store addressing to the microsequencer and releases the CPU from reset. The block sits directly upstream of the sequencer/control-store RAM and replaces the ad-hoc copy logic gated on `cs_ready`.

## Interface
- `ADDR_WIDTH`, 8: control-store address width; DEPTH = 2**ADDR_WIDTH words.
- `DATA_WIDTH`, 64: microinstruction width.
- `READ_LATENCY`, 1: cycles from address change to valid `rom_data` / `ram_rdata` (≥1).
- `VERIFY`, 1: 1 = run a readback-compare pass after loading; 0 = skip it.
- `AUTO_START`, 1: 1 = start loading automatically after reset; 0 = wait for `start`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to (re)load. Honoured only in IDLE, DONE or FAIL.
- `rom_addr` out ADDR_WIDTH: EPROM address.
- `rom_data` in DATA_WIDTH: EPROM read data.
- `ram_addr` out ADDR_WIDTH: control-store RAM address while loading.
- `ram_wdata` out DATA_WIDTH: RAM write data.
- `cs_ram__w` out 1: RAM write strobe, active low.
- `ram_rdata` in DATA_WIDTH: RAM read data, used for verify.
- `busy` out 1: high in LOAD and VERIFY states.
- `cs_ready` out 1: control store valid; sequencer owns the RAM.
- `verify_error` out 1: sticky readback mismatch flag.
- `error_addr` out ADDR_WIDTH: address of the first mismatch.

## Operation
- States: IDLE, FETCH, SETUP, STROBE, HOLD, VFETCH, VCMP, DONE, FAIL.
- Reset values (registered outputs): `rom_addr`=0, `ram_addr`=0, `ram_wdata`=0, `cs_ram__w`=1, `busy`=0, `cs_ready`=0, `verify_error`=0, `error_addr`=0.
- Reset asserted in any state → IDLE at the next edge, with reset values. A partially loaded store is abandoned, and no write strobe may remain low.
- IDLE → FETCH when AUTO_START=1 (unconditionally, one cycle after reset release) or when `start`=1. The index counter is cleared to 0.
- FETCH: `rom_addr`=`ram_addr`=index. Stays READ_LATENCY cycles, then captures `rom_data` into `ram_wdata`.
- SETUP: one cycle; `cs_ram__w`=1; address and data stable.
- STROBE: one cycle; `cs_ram__w`=0.
- HOLD: one cycle; `cs_ram__w`=1; address and data unchanged.
  - If index ≠ DEPTH-1: increment index → FETCH.
  - Else: → VFETCH with index=0 (VERIFY=1), or → DONE (VERIFY=0).
- Index never wraps. The word at DEPTH-1 is written exactly once and terminates the pass.
- VFETCH: both addresses = index; `cs_ram__w`=1. Stays READ_LATENCY cycles.
- VCMP: compares `rom_data` with `ram_rdata`.
  - Mismatch → FAIL; `verify_error`=1; `error_addr`=index.
  - Equal and index ≠ DEPTH-1 → increment index → VFETCH.
  - Equal at DEPTH-1 → DONE.
- DONE: `cs_ready`=1; `busy`=0; `cs_ram__w` held at 1. `start` → FETCH, and `cs_ready` drops at that same edge.
- FAIL: terminal; `cs_ready`=0. `start` → FETCH and clears `verify_error` and `error_addr`.
- `start` is ignored while `busy`=1.
- `cs_ram__w` is 0 only in STROBE, never in any other state.

## Timing
- All outputs are registered; state changes occur on rising `clk` edges.
- Load pass: DEPTH×(READ_LATENCY+3) cycles. Verify pass: DEPTH×(READ_LATENCY+1) cycles.
- `cs_ready` rises 1 + DEPTH×(READ_LATENCY+3) + VERIFY×DEPTH×(READ_LATENCY+1) edges after the first edge that samples `reset`=0 (AUTO_START=1). With the defaults this is 1+1024+512 = 1537.
- Address and data stay stable for one full cycle before and after every strobe-low cycle.
- A mismatch is flagged at the VCMP edge. FAIL is entered at that same edge; no further reads occur.

## Test plan
- Defaults, ROM filled with pattern word[i]={8{i}}, RAM model behaves correctly → exactly 256 strobe pulses, each one cycle low; RAM equals ROM; `cs_ready` rises at edge 1537 with `verify_error`=0.
- RAM model corrupts bit 5 of the word at address 8'h3C → FAIL; `verify_error`=1; `error_addr`=8'h3C; `cs_ready` stays 0. A following `start` reload with a good RAM → DONE.
- Assert `reset` for one cycle midway through the load (index 8'h80, during STROBE) → next edge: `cs_ram__w`=1, `busy`=0, state IDLE. The next run completes with all 256 words correct.
- VERIFY=0, READ_LATENCY=2 → `cs_ready` rises at edge 1+256×5 = 1281. Verify that no compare is performed.
- AUTO_START=0 → outputs remain at reset values for 100 cycles. A `start` pulse begins the load; `start` pulses sent while busy have no effect, and the count of strobes stays 256.
- In DONE, pulse `start` → `cs_ready` drops at the same edge and re-asserts after another full 1536-cycle load and verify.
